// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sharing a bank of SR flops among several requesters.
// Clears the bank after reset, keeps a shadow of every flop and flags illegal commands.
module sr_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [IDXW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]        req_ready,
    output logic [2*NFF-1:0]       sr_out,
    output logic [NFF-1:0]         q_shadow,
    output logic                   busy,
    output logic                   err,
    output logic [2:0]             err_id
);

    localparam int unsigned NR = NREQ;
    localparam int unsigned NF = NFF;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_APPLY,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_ini_cnt;
    logic [2:0]        r_rr_ptr;
    logic [1:0]        r_op;
    logic [IDXW-1:0]   r_idx;
    logic [2:0]        r_id;
    logic [NFF-1:0]    r_shadow;
    logic              r_err;
    logic [2:0]        r_err_id;

    logic              w_hit;
    logic [2:0]        w_win;
    logic [1:0]        w_win_op;
    logic [IDXW-1:0]   w_win_idx;
    logic              w_legal;
    int unsigned       w_best;
    int unsigned       w_dist;

    // Winner is the valid requester with the smallest distance above rr_ptr (mod NREQ).
    always_comb begin
        w_hit     = 1'b0;
        w_win     = '0;
        w_win_op  = '0;
        w_win_idx = '0;
        w_best    = NR;
        w_dist    = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            w_dist = (i + NR - 32'(r_rr_ptr)) % NR;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_hit     = 1'b1;
                w_win     = 3'(i);
                w_win_op  = req_op[2*i +: 2];
                w_win_idx = req_idx[IDXW*i +: IDXW];
            end
        end
    end

    assign w_legal = (r_op != 2'b11) && (32'(r_idx) < NF);

    always_comb begin
        w_state_nxt = r_state;
        sr_out      = '0;
        req_ready   = '0;
        busy        = 1'b1;
        case (r_state)
            S_INIT: begin
                for (int unsigned j = 0; j < NF; j++) begin
                    if (r_ini_cnt == IDXW'(j)) begin
                        sr_out[2*j +: 2] = 2'b01;
                    end
                end
                if (r_ini_cnt == IDXW'(NF - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                busy = 1'b0;
                if (w_hit) begin
                    for (int unsigned i = 0; i < NR; i++) begin
                        req_ready[i] = (w_win == 3'(i));
                    end
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                for (int unsigned j = 0; j < NF; j++) begin
                    if (w_legal && (r_idx == IDXW'(j))) begin
                        sr_out[2*j +: 2] = r_op;
                    end
                end
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_INIT;
            r_ini_cnt <= '0;
            r_rr_ptr  <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_id      <= '0;
            r_shadow  <= '0;
            r_err     <= 1'b0;
            r_err_id  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_INIT: begin
                    r_ini_cnt <= r_ini_cnt + 1'b1;
                    for (int unsigned j = 0; j < NF; j++) begin
                        if (r_ini_cnt == IDXW'(j)) begin
                            r_shadow[j] <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_hit) begin
                        r_op     <= w_win_op;
                        r_idx    <= w_win_idx;
                        r_id     <= w_win;
                        r_rr_ptr <= 3'((32'(w_win) + 1) % NR);
                    end
                end
                S_APPLY: begin
                    if (w_legal) begin
                        for (int unsigned j = 0; j < NF; j++) begin
                            if (r_idx == IDXW'(j)) begin
                                if (r_op == 2'b10) begin
                                    r_shadow[j] <= 1'b1;
                                end else if (r_op == 2'b01) begin
                                    r_shadow[j] <= 1'b0;
                                end
                            end
                        end
                    end else if (!r_err) begin
                        r_err    <= 1'b1;
                        r_err_id <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_shadow = r_shadow;
    assign err      = r_err;
    assign err_id   = r_err_id;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: transaction-level model predicts grants, bank drive,
// shadow and error state; a monitor compares every cycle against the DUT.
module tb_sr_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NFF  = 8;
    localparam int IDXW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [2*NREQ-1:0]     req_op = '0;
    logic [IDXW*NREQ-1:0]  req_idx = '0;
    logic [NREQ-1:0]       req_ready;
    logic [2*NFF-1:0]      sr_out;
    logic [NFF-1:0]        q_shadow;
    logic                  busy;
    logic                  err;
    logic [2:0]            err_id;

    sr_bank_arbiter #(
        .NREQ (NREQ),
        .NFF  (NFF),
        .IDXW (IDXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .sr_out    (sr_out),
        .q_shadow  (q_shadow),
        .busy      (busy),
        .err       (err),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         apply;
        int         id;
        logic [1:0] op;
        int         idx;
    } txn_t;

    txn_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [1:0] op, input int idx);
        return (op != 2'b11) && (idx < NFF);
    endfunction

    // Monitor and reference model.
    initial begin
        bit               synced;
        int               m_ptr;
        int               m_next;
        logic [NFF-1:0]   m_sh;
        logic             m_err;
        logic [2:0]       m_eid;
        logic [2*NFF-1:0] exp_sr;
        logic             exp_busy;
        logic [NREQ-1:0]  exp_rdy;
        logic [NREQ-1:0]  pend;
        int               since [NREQ];
        int               win;
        int               c;
        txn_t             t;
        synced = 0;
        m_ptr  = 0;
        m_next = NFF;
        m_sh   = '0;
        m_err  = 1'b0;
        m_eid  = '0;
        pend   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                synced = 1;
                cyc    = -1;
                q.delete();
                m_ptr  = 0;
                m_next = NFF;
                m_sh   = '0;
                m_err  = 1'b0;
                m_eid  = '0;
                pend   = '0;
            end else if (synced) begin
                cyc++;
                exp_sr   = '0;
                exp_busy = 1'b0;
                if (cyc < NFF) begin
                    exp_sr[2*cyc +: 2] = 2'b01;
                    exp_busy = 1'b1;
                end else if (q.size() > 0 && q[0].apply == cyc) begin
                    exp_busy = 1'b1;
                    if (is_legal(q[0].op, q[0].idx)) exp_sr[2*q[0].idx +: 2] = q[0].op;
                end else if (q.size() > 0 && q[0].apply + 1 == cyc) begin
                    exp_busy = 1'b1;
                    t = q.pop_front();
                    if (is_legal(t.op, t.idx)) begin
                        if (t.op == 2'b10) m_sh[t.idx] = 1'b1;
                        if (t.op == 2'b01) m_sh[t.idx] = 1'b0;
                    end else if (!m_err) begin
                        m_err = 1'b1;
                        m_eid = 3'(t.id);
                    end
                end
                chk("sr_out", 32'(sr_out), 32'(exp_sr));
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("q_shadow", 32'(q_shadow), 32'(m_sh));
                chk("err", 32'(err), 32'(m_err));
                chk("err_id", 32'(err_id), 32'(m_eid));

                win = -1;
                if (cyc >= m_next) begin
                    for (int k = 0; k < NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (win < 0 && req_valid[c]) win = c;
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (win >= 0) begin
                    q.push_back('{apply: cyc + 1, id: win, op: req_op[2*win +: 2],
                                  idx: int'(req_idx[IDXW*win +: IDXW])});
                    m_ptr  = (win + 1) % NREQ;
                    m_next = cyc + 3;
                end

                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i]) begin
                        if (!pend[i]) begin
                            pend[i]  = 1'b1;
                            since[i] = (cyc < NFF) ? NFF : cyc;
                        end
                        if (req_ready[i]) begin
                            chk("wait_bound", 32'((cyc - since[i]) <= 3 * NREQ), 32'd1);
                            pend[i] = 1'b0;
                        end
                    end else begin
                        pend[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input int r, input logic [1:0] op, input int idx, input bit rst_after);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        req_valid[r]            = 1'b1;
        req_op[2*r +: 2]        = op;
        req_idx[IDXW*r +: IDXW] = IDXW'(idx);
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout requester %0d: got no grant, expected one within 60 cycles", r);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        if (rst_after) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Stimulus.
    initial begin
        logic [NREQ-1:0] hs;
        logic [NREQ-1:0] left;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 2'b10, 5, 0);
        issue(0, 2'b01, 5, 0);
        issue(3, 2'b10, 6, 0);
        issue(0, 2'b10, 2, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]            = 1'b1;
            req_op[2*i +: 2]        = 2'b10;
            req_idx[IDXW*i +: IDXW] = IDXW'(i);
        end
        left = '1;
        for (int n = 0; n < 60 && left != '0; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            left = left & ~hs;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~hs;
        end
        if (left != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL all_valid_timeout: got pending %0b, expected 0", left);
        end
        req_valid = '0;

        issue(2, 2'b11, 3, 0);
        issue(1, 2'b10, 9, 0);
        issue(1, 2'b00, 4, 0);

        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i]     = 1'b1;
                        req_op[2*i +: 2] = 2'($urandom_range(0, 3));
                        req_idx[IDXW*i +: IDXW] = ($urandom_range(0, 7) == 0) ?
                            IDXW'($urandom_range(NFF, 15)) : IDXW'($urandom_range(0, NFF - 1));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
